command_sequencer: RTL

Synchronous command parser and sequencer between the UART receiver and the LED matrix display core. Consumes received bytes as one-cycle strobes, decodes single- and multi-byte commands, holds the channel-enable and brightness configuration registers, and drives the frame-buffer write port for single-pixel writes and full-panel fills. All logic runs on `clk_in`; the write port is shared, so every write waits for `fb_wr_ready`.

---
 rtl/led_matrix_pkg.sv | 36 +++
 rtl/cmd_timeout_timer.sv | 50 +++++
 rtl/command_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_pkg
// Shared definitions for the LED matrix command path: opcode bytes accepted by
// command_sequencer, the sequencer state encoding, and the number of argument
// bytes that follow each multi-byte opcode.
// No ports (package only).
// -----------------------------------------------------------------------------
package led_matrix_pkg;

    // Single-byte opcodes (ASCII)
    localparam logic [7:0] OP_RED_SET   = 8'h52; // 'R'
    localparam logic [7:0] OP_RED_CLR   = 8'h72; // 'r'
    localparam logic [7:0] OP_GRN_SET   = 8'h47; // 'G'
    localparam logic [7:0] OP_GRN_CLR   = 8'h67; // 'g'
    localparam logic [7:0] OP_BLU_SET   = 8'h42; // 'B'
    localparam logic [7:0] OP_BLU_CLR   = 8'h62; // 'b'
    localparam logic [7:0] OP_CLR_FLAGS = 8'h58; // 'X'

    // Multi-byte opcodes (ASCII)
    localparam logic [7:0] OP_BRIGHT    = 8'h4C; // 'L' + level
    localparam logic [7:0] OP_PIXEL     = 8'h50; // 'P' + row, col, r, g, b
    localparam logic [7:0] OP_FILL      = 8'h46; // 'F' + r, g, b

    // Argument byte counts for the multi-byte opcodes
    localparam logic [2:0] ARGS_BRIGHT  = 3'd1;
    localparam logic [2:0] ARGS_PIXEL   = 3'd5;
    localparam logic [2:0] ARGS_FILL    = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_WRITE,
        ST_FILL
    } state_t;

endpackage

// File: rtl/cmd_timeout_timer.sv
// -----------------------------------------------------------------------------
// cmd_timeout_timer
// Inter-byte timeout counter for the command sequencer. Counts cycles while
// run_i is high and clear_i is low; expired_o flags the cycle in which the
// count reaches TIMEOUT_CYCLES.
// Ports:
//   clk_in     in  system clock
//   reset      in  asynchronous active-high reset
//   clear_i    in  restart the count (a byte arrived or not waiting)
//   run_i      in  count enable (waiting for an argument byte)
//   expired_o  out timeout reached in this cycle
// -----------------------------------------------------------------------------
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 70000,
    parameter int COUNT_WIDTH    = 17
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LAST_COUNT)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count saturates at LAST_COUNT, so expiry is the TIMEOUT_CYCLES-th
    // consecutive waiting cycle without a byte.
    assign expired_o = run_i && !clear_i && (cnt_q == LAST_COUNT);

endmodule

// File: rtl/command_sequencer.sv
// -----------------------------------------------------------------------------
// command_sequencer
// Parses bytes from the UART receiver into LED matrix commands: channel
// enables, brightness, single-pixel writes and full-panel fills. Drives the
// shared frame-buffer write port, holding each request until fb_wr_ready.
// Optional feature macro: CMD_TIMEOUT_EN -- when defined, an inter-byte
// timeout aborts a partially received command after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk_in        in  system clock
//   reset         in  asynchronous active-high reset
//   rx_data       in  received byte (qualified by rx_valid)
//   rx_valid      in  one-cycle byte strobe
//   rx_invalid    in  framing error for the current byte
//   fb_wr_ready   in  frame-buffer port accepts the write this cycle
//   fb_wr_en      out write request, held until accepted
//   fb_wr_addr    out write address {row, col}
//   fb_wr_data    out pixel {r, g, b}
//   enable_red/green/blue out channel enables
//   brightness    out global brightness
//   busy          out not in IDLE
//   error         out sticky: command aborted (framing error / timeout)
//   overrun       out sticky: byte dropped during WRITE or FILL
// -----------------------------------------------------------------------------
module command_sequencer
    import led_matrix_pkg::*;
#(
    parameter int ROW_WIDTH      = 5,
    parameter int COL_WIDTH      = 6,
    parameter int BRIGHT_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 70000,
    parameter int TIMEOUT_WIDTH  = 17
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    input  logic                           rx_invalid,
    input  logic                           fb_wr_ready,
    output logic                           fb_wr_en,
    output logic [ROW_WIDTH+COL_WIDTH-1:0] fb_wr_addr,
    output logic [23:0]                    fb_wr_data,
    output logic                           enable_red,
    output logic                           enable_green,
    output logic                           enable_blue,
    output logic [BRIGHT_WIDTH-1:0]        brightness,
    output logic                           busy,
    output logic                           error,
    output logic                           overrun
);

    localparam int ADDR_WIDTH = ROW_WIDTH + COL_WIDTH;

    state_t                  state_q,   state_d;
    logic [7:0]              op_q,      op_d;
    logic [2:0]              arg_cnt_q, arg_cnt_d;
    logic [2:0]              arg_idx_q, arg_idx_d;
    logic [3:0][7:0]         args_q,    args_d;     // last argument is used straight from rx_data
    logic                    en_red_q,  en_red_d;
    logic                    en_grn_q,  en_grn_d;
    logic                    en_blu_q,  en_blu_d;
    logic [BRIGHT_WIDTH-1:0] bright_q,  bright_d;
    logic                    wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [23:0]             data_q,    data_d;
    logic                    error_q,   error_d;
    logic                    overrun_q, overrun_d;

    logic                    timeout_expired;

`ifdef CMD_TIMEOUT_EN
    logic timer_run;
    logic timer_clear;

    // The timer only runs while waiting for arguments; any byte restarts it.
    assign timer_run   = (state_q == ST_ARG);
    assign timer_clear = rx_valid || !timer_run;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .COUNT_WIDTH    (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk_in    (clk_in),
        .reset     (reset),
        .clear_i   (timer_clear),
        .run_i     (timer_run),
        .expired_o (timeout_expired)
    );
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES) ^ 32'(TIMEOUT_WIDTH);
    assign timeout_expired    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_cnt_d = arg_cnt_q;
        arg_idx_d = arg_idx_q;
        args_d    = args_q;
        en_red_d  = en_red_q;
        en_grn_d  = en_grn_q;
        en_blu_d  = en_blu_q;
        bright_d  = bright_q;
        wr_en_d   = wr_en_q;
        addr_d    = addr_q;
        data_d    = data_q;
        error_d   = error_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                // Bytes with a framing error are silently skipped here.
                if (rx_valid && !rx_invalid) begin
                    case (rx_data)
                        OP_RED_SET:   en_red_d = 1'b1;
                        OP_RED_CLR:   en_red_d = 1'b0;
                        OP_GRN_SET:   en_grn_d = 1'b1;
                        OP_GRN_CLR:   en_grn_d = 1'b0;
                        OP_BLU_SET:   en_blu_d = 1'b1;
                        OP_BLU_CLR:   en_blu_d = 1'b0;
                        OP_CLR_FLAGS: begin
                            error_d   = 1'b0;
                            overrun_d = 1'b0;
                        end
                        OP_BRIGHT, OP_PIXEL, OP_FILL: begin
                            op_d      = rx_data;
                            arg_idx_d = 3'd0;
                            arg_cnt_d = (rx_data == OP_BRIGHT) ? ARGS_BRIGHT :
                                        (rx_data == OP_PIXEL)  ? ARGS_PIXEL  : ARGS_FILL;
                            state_d   = ST_ARG;
                        end
                        default: ;
                    endcase
                end
            end

            ST_ARG: begin
                if (rx_valid) begin
                    if (rx_invalid) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (arg_idx_q == (arg_cnt_q - 3'd1)) begin
                        // Final argument: act on it directly from rx_data.
                        case (op_q)
                            OP_BRIGHT: begin
                                bright_d = rx_data[BRIGHT_WIDTH-1:0];
                                state_d  = ST_IDLE;
                            end
                            OP_PIXEL: begin
                                addr_d  = {args_q[0][ROW_WIDTH-1:0], args_q[1][COL_WIDTH-1:0]};
                                data_d  = {args_q[2], args_q[3], rx_data};
                                wr_en_d = 1'b1;
                                state_d = ST_WRITE;
                            end
                            OP_FILL: begin
                                addr_d  = '0;
                                data_d  = {args_q[0], args_q[1], rx_data};
                                wr_en_d = 1'b1;
                                state_d = ST_FILL;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end else begin
                        args_d[arg_idx_q[1:0]] = rx_data;
                        arg_idx_d              = arg_idx_q + 3'd1;
                    end
                end else if (timeout_expired) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (fb_wr_ready) begin
                    wr_en_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_FILL: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (fb_wr_ready) begin
                    if (&addr_q) begin
                        wr_en_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            arg_cnt_q <= '0;
            arg_idx_q <= '0;
            args_q    <= '0;
            en_red_q  <= 1'b1;
            en_grn_q  <= 1'b1;
            en_blu_q  <= 1'b1;
            bright_q  <= '1;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            arg_cnt_q <= arg_cnt_d;
            arg_idx_q <= arg_idx_d;
            args_q    <= args_d;
            en_red_q  <= en_red_d;
            en_grn_q  <= en_grn_d;
            en_blu_q  <= en_blu_d;
            bright_q  <= bright_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
        end
    end

    assign fb_wr_en     = wr_en_q;
    assign fb_wr_addr   = addr_q;
    assign fb_wr_data   = data_q;
    assign enable_red   = en_red_q;
    assign enable_green = en_grn_q;
    assign enable_blue  = en_blu_q;
    assign brightness   = bright_q;
    assign busy         = (state_q != ST_IDLE);
    assign error        = error_q;
    assign overrun      = overrun_q;

endmodule
